// File: rtl/ws2812_pattern_engine_if.sv
// Frame handoff between the pattern engine and the ws2812_chain serializer.
interface ws2812_pattern_engine_if #(
  parameter int NUM_LEDS = 16
);
  logic                     chain_start;
  logic                     chain_done;
  logic [NUM_LEDS*24-1:0]   led_data;

  modport master (output chain_start, output led_data, input chain_done);
  modport slave  (input chain_start, input led_data, output chain_done);
endinterface

// File: rtl/ws2812_pattern_engine.sv
// Frame-based WS2812 animation engine: builds one GRB frame per frame period,
// one LED per cycle, then hands it to ws2812_chain via start/done.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for a frame tick
// S_LATCH     | sample pattern/brightness, clear animation on pattern change
// S_BUILD     | write one LED word per cycle into led_data
// S_START     | one cycle before the registered chain_start pulse
// S_WAIT_DONE | frame shifting out; commit and animate on chain_done
module ws2812_pattern_engine #(
  parameter int          NUM_LEDS     = 16,
  parameter int          FRAME_CYCLES = 2_083_333,
  parameter int          BLINK_FRAMES = 30,
  parameter int          CHASE_FRAMES = 4,
  parameter int          FADE_STEP    = 4,
  parameter int          HUE_STEP     = 8,
  parameter int          HUE_SPACING  = 64,
  parameter logic [23:0] COLOR_A      = 24'h00FF00,
  parameter logic [23:0] COLOR_B      = 24'h0000FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  pattern_select,
  input  logic [7:0]  brightness,
  input  logic        enable,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic        overrun,
  ws2812_pattern_engine_if.master chain
);

  localparam int TW = $clog2(FRAME_CYCLES + 1);
  localparam int IW = $clog2(NUM_LEDS);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_BUILD, S_START, S_WAIT_DONE} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic            tick;
  logic [2:0]      pat_r;
  logic [7:0]      bri_r;
  logic [2:0]      last_pattern;
  logic [IW-1:0]   led_idx;
  logic [IW-1:0]   chase_pos;
  logic [15:0]     chase_cnt;
  logic            blink_phase;
  logic [15:0]     blink_cnt;
  logic [7:0]      fade_level;
  logic            fade_down;
  logic [10:0]     hue_offset;
  logic [31:0]     hue_sum;
  logic [10:0]     hue;
  logic [23:0]     raw;
  logic [23:0]     colour;

  function automatic logic [23:0] hsv_grb(input logic [10:0] h);
    logic [7:0] r, g, b, rem;
    rem = h[7:0];
    r = 8'd0; g = 8'd0; b = 8'd0;
    case (h[10:8])
      3'd0: begin r = 8'd255;       g = rem;          b = 8'd0;         end
      3'd1: begin r = 8'd255 - rem; g = 8'd255;       b = 8'd0;         end
      3'd2: begin r = 8'd0;         g = 8'd255;       b = rem;          end
      3'd3: begin r = 8'd0;         g = 8'd255 - rem; b = 8'd255;       end
      3'd4: begin r = rem;          g = 8'd0;         b = 8'd255;       end
      3'd5: begin r = 8'd255;       g = 8'd0;         b = 8'd255 - rem; end
      default: begin r = 8'd0; g = 8'd0; b = 8'd0; end
    endcase
    return {g, r, b};
  endfunction

  // bri+1 keeps 255 an exact identity and 0 a full blackout
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction

  assign tick = enable && (timer == TW'(FRAME_CYCLES - 1));

  // Frame period timer, parked at 0 while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               timer <= '0;
    else if (!enable)                         timer <= '0;
    else if (timer == TW'(FRAME_CYCLES - 1))  timer <= '0;
    else                                      timer <= timer + 1'b1;
  end

  // Raw pattern colour of the LED being built, then brightness scaling
  always_comb begin
    hue_sum = 32'(hue_offset) + 32'(led_idx) * 32'(HUE_SPACING);
    hue     = 11'(hue_sum % 32'd1536);
    raw     = 24'h0;
    case (pat_r)
      3'd0: raw = (led_idx == chase_pos) ? COLOR_A : 24'h0;
      3'd1: raw = blink_phase ? COLOR_A : 24'h0;
      3'd2: raw = (led_idx[0] ^ blink_phase) ? 24'h0 : COLOR_B;
      3'd3: raw = {fade_level, 16'h0};
      3'd4: raw = hsv_grb(hue);
      default: raw = 24'h0;
    endcase
    colour = {scale(raw[23:16], bri_r), scale(raw[15:8], bri_r), scale(raw[7:0], bri_r)};
  end

  // Frame sequencer, frame buffer and per-frame animation state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      pat_r             <= 3'd0;
      bri_r             <= 8'd0;
      last_pattern      <= 3'd0;
      led_idx           <= '0;
      chase_pos         <= '0;
      chase_cnt         <= 16'(CHASE_FRAMES - 1);
      blink_phase       <= 1'b0;
      blink_cnt         <= 16'(BLINK_FRAMES - 1);
      fade_level        <= 8'd0;
      fade_down         <= 1'b0;
      hue_offset        <= 11'd0;
      busy              <= 1'b0;
      frame_count       <= 16'd0;
      overrun           <= 1'b0;
      chain.chain_start <= 1'b0;
      chain.led_data    <= '0;
    end else begin
      chain.chain_start <= 1'b0;
      if (tick && state != S_IDLE) overrun <= 1'b1;
      case (state)
        S_IDLE: if (tick) state <= S_LATCH;
        S_LATCH: begin
          pat_r   <= pattern_select;
          bri_r   <= brightness;
          led_idx <= '0;
          busy    <= 1'b1;
          if (pattern_select != last_pattern) begin
            last_pattern <= pattern_select;
            chase_pos    <= '0;
            chase_cnt    <= 16'(CHASE_FRAMES - 1);
            blink_phase  <= 1'b0;
            blink_cnt    <= 16'(BLINK_FRAMES - 1);
            fade_level   <= 8'd0;
            fade_down    <= 1'b0;
            hue_offset   <= 11'd0;
          end
          state <= S_BUILD;
        end
        S_BUILD: begin
          chain.led_data[32'(led_idx)*24 +: 24] <= colour;
          if (led_idx == IW'(NUM_LEDS - 1)) state <= S_START;
          else                              led_idx <= led_idx + 1'b1;
        end
        S_START: begin
          chain.chain_start <= 1'b1;
          state             <= S_WAIT_DONE;
        end
        S_WAIT_DONE: if (chain.chain_done) begin
          busy        <= 1'b0;
          frame_count <= frame_count + 16'd1;
          if (chase_cnt == 16'd0) begin
            chase_cnt <= 16'(CHASE_FRAMES - 1);
            chase_pos <= (chase_pos == IW'(NUM_LEDS - 1)) ? '0 : chase_pos + 1'b1;
          end else chase_cnt <= chase_cnt - 16'd1;
          if (blink_cnt == 16'd0) begin
            blink_cnt   <= 16'(BLINK_FRAMES - 1);
            blink_phase <= ~blink_phase;
          end else blink_cnt <= blink_cnt - 16'd1;
          if (!fade_down) begin
            if ({1'b0, fade_level} + 9'(FADE_STEP) >= 9'd255) begin
              fade_level <= 8'd255;
              fade_down  <= 1'b1;
            end else fade_level <= fade_level + 8'(FADE_STEP);
          end else begin
            if ({1'b0, fade_level} <= 9'(FADE_STEP)) begin
              fade_level <= 8'd0;
              fade_down  <= 1'b0;
            end else fade_level <= fade_level - 8'(FADE_STEP);
          end
          hue_offset <= 11'((32'(hue_offset) + 32'(HUE_STEP)) % 32'd1536);
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_pattern_engine.sv
// Randomized self-checking bench for ws2812_pattern_engine against a
// frame-number based reference model.
module tb_ws2812_pattern_engine;
  localparam int NL = 4;
  localparam int FC = 100;
  localparam int BF = 2;
  localparam int CF = 1;
  localparam int FS = 4;
  localparam int HS = 8;
  localparam int SP = 64;
  localparam logic [23:0] CA = 24'h00FF00;
  localparam logic [23:0] CB = 24'h0000FF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  pattern_select;
  logic [7:0]  brightness;
  logic        enable;
  logic        busy;
  logic [15:0] frame_count;
  logic        overrun;

  ws2812_pattern_engine_if #(.NUM_LEDS(NL)) chain_if();

  ws2812_pattern_engine #(
    .NUM_LEDS(NL), .FRAME_CYCLES(FC), .BLINK_FRAMES(BF), .CHASE_FRAMES(CF),
    .FADE_STEP(FS), .HUE_STEP(HS), .HUE_SPACING(SP), .COLOR_A(CA), .COLOR_B(CB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pattern_select(pattern_select),
    .brightness(brightness), .enable(enable), .busy(busy),
    .frame_count(frame_count), .overrun(overrun), .chain(chain_if)
  );

  always #4 clk = ~clk;

  int cyc;
  int starts_total = 0;
  int checks = 0;
  int errors = 0;
  int m_n, m_last, m_fc, exp_starts, start_cyc;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  always @(negedge clk) if (chain_if.chain_start) starts_total <= starts_total + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] m_scale(input logic [23:0] w, input int b);
    int g, r, bl;
    g  = (int'(w[23:16]) * (b + 1)) / 256;
    r  = (int'(w[15:8])  * (b + 1)) / 256;
    bl = (int'(w[7:0])   * (b + 1)) / 256;
    return {8'(g), 8'(r), 8'(bl)};
  endfunction

  function automatic logic [23:0] m_hsv(input int h);
    int reg_n, rem, r, g, b;
    reg_n = h / 256; rem = h % 256;
    case (reg_n)
      0: begin r = 255;       g = rem;       b = 0;         end
      1: begin r = 255 - rem; g = 255;       b = 0;         end
      2: begin r = 0;         g = 255;       b = rem;       end
      3: begin r = 0;         g = 255 - rem; b = 255;       end
      4: begin r = rem;       g = 0;         b = 255;       end
      default: begin r = 255; g = 0;         b = 255 - rem; end
    endcase
    return {8'(g), 8'(r), 8'(b)};
  endfunction

  // Triangle wave of the fade level after n committed frames
  function automatic int m_fade(input int n);
    int lvl = 0;
    bit up = 1;
    for (int k = 0; k < n; k++) begin
      if (up) begin
        if (lvl + FS >= 255) begin lvl = 255; up = 0; end
        else lvl = lvl + FS;
      end else begin
        if (lvl <= FS) begin lvl = 0; up = 1; end
        else lvl = lvl - FS;
      end
    end
    return lvl;
  endfunction

  function automatic logic [23:0] m_led(input int pat, input int n, input int i);
    case (pat)
      0: return ((n / CF) % NL == i) ? CA : 24'h0;
      1: return ((n / BF) % 2 == 1) ? CA : 24'h0;
      2: return ((i + (n / BF) % 2) % 2 == 0) ? CB : 24'h0;
      3: return {8'(m_fade(n)), 16'h0};
      4: return m_hsv((n * HS + i * SP) % 1536);
      default: return 24'h0;
    endcase
  endfunction

  // One complete frame: latch, optional disturbance, start, check, done
  task automatic run_frame(input int pat, input int bri, input int dly,
                           input int glitch_pat, input bit drop_en);
    int k;
    int latch_cyc;
    bit seen;
    pattern_select = 3'(pat);
    brightness     = 8'(bri);
    k = 0;
    while (!((cyc % FC) == 1 && cyc > FC) && k < 3 * FC) begin @(negedge clk); k++; end
    check("latch_wait", ((cyc % FC) == 1), 1);
    latch_cyc = cyc;
    if (pat != m_last) begin m_n = 0; m_last = pat; end
    if (drop_en) enable = 1'b0;
    if (glitch_pat >= 0) begin
      pattern_select = 3'(glitch_pat);
      brightness     = 8'($urandom);
      @(negedge clk); chain_if.chain_done = 1'b1;
      @(negedge clk); chain_if.chain_done = 1'b0;
    end
    k = 0;
    while (!chain_if.chain_start && k < 2 * FC) begin @(negedge clk); k++; end
    seen = chain_if.chain_start;
    check("start_seen", seen, 1);
    start_cyc = cyc;
    check("start_latency", cyc - latch_cyc, 5);
    check("busy_frame", busy, 1);
    for (int i = 0; i < NL; i++)
      check($sformatf("led%0d_p%0d_n%0d", i, pat, m_n),
            chain_if.led_data[i*24 +: 24], m_scale(m_led(pat, m_n, i), bri));
    repeat (dly - 1) @(negedge clk);
    chain_if.chain_done = 1'b1;
    @(negedge clk);
    chain_if.chain_done = 1'b0;
    m_n++; m_fc = (m_fc + 1) % 65536; exp_starts++;
    check("busy_after_done", busy, 0);
    check("frame_count", frame_count, m_fc);
    check("start_count", starts_total, exp_starts);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, chain_if.chain_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fc"}, frame_count, 0);
    check({tag, "_ovr"}, overrun, 0);
    check({tag, "_leds"}, chain_if.led_data, 0);
  endtask

  initial begin
    int k, pat, bri;
    rst_n = 1'b0; enable = 1'b1; pattern_select = 3'd0; brightness = 8'd255;
    chain_if.chain_done = 1'b0;
    m_n = 0; m_last = 0; m_fc = 0; exp_starts = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // chase, full brightness, periodic starts
    for (int f = 0; f < 5; f++) begin
      run_frame(0, 255, 20, -1, 0);
      check("start_cycle", start_cyc, 106 + 100 * f);
    end
    check("fc_after_5", frame_count, 5);

    run_frame(0, 128, 20, -1, 0);
    check("bri128_red", chain_if.led_data[1*24 +: 24], 24'h008000);
    run_frame(0, 0, 20, -1, 0);
    check("bri0_dark", chain_if.led_data, 0);

    run_frame(4, 255, 15, -1, 0);
    check("hue_led0", chain_if.led_data[0*24 +: 24], 24'h00FF00);
    check("hue_led1", chain_if.led_data[1*24 +: 24], 24'h40FF00);
    check("hue_led3", chain_if.led_data[3*24 +: 24], 24'hC0FF00);

    // fade up to 255, back down to 0 and up again
    for (int f = 0; f < 140; f++) begin
      run_frame(3, 255, $urandom_range(1, 40), -1, 0);
      if (f == 64)  check("fade_top", chain_if.led_data[23:16], 8'hFF);
      if (f == 65)  check("fade_turn", chain_if.led_data[23:16], 8'hFB);
      if (f == 128) check("fade_bottom", chain_if.led_data[23:16], 8'h00);
      if (f == 129) check("fade_rise", chain_if.led_data[23:16], 8'h04);
    end

    // pattern changed mid-build: takes effect next frame, animation cleared
    run_frame(0, 255, 10, -1, 0);
    run_frame(0, 255, 10, 2, 0);
    run_frame(2, 255, 10, -1, 0);
    run_frame(0, 255, 10, -1, 0);
    check("chase_restart_led0", chain_if.led_data[0*24 +: 24], CA);
    check("chase_restart_led1", chain_if.led_data[1*24 +: 24], 24'h0);

    // randomized frames
    pat = 0;
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 1) == 1) pat = $urandom_range(0, 7);
      bri = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
      run_frame(pat, bri, $urandom_range(1, 40),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1, 0);
    end

    // overrun: done withheld for 250 cycles
    check("ovr_before", overrun, 0);
    run_frame(1, 255, 250, -1, 0);
    check("ovr_set", overrun, 1);
    run_frame(1, 255, 10, -1, 0);
    check("ovr_sticky", overrun, 1);

    // reset in the middle of a build
    pattern_select = 3'd0;
    k = 0;
    while (!((cyc % FC) == 3 && cyc > FC) && k < 3 * FC) begin @(negedge clk); k++; end
    check("build_wait", ((cyc % FC) == 3), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    m_n = 0; m_last = 0; m_fc = 0;
    run_frame(0, 255, 10, -1, 0);
    check("start_after_reset", start_cyc, 106);
    check("led0_after_reset", chain_if.led_data[0*24 +: 24], CA);

    // enable dropped mid-frame: frame completes, then engine stays idle
    run_frame(0, 255, 10, -1, 1);
    repeat (3 * FC) @(negedge clk);
    check("disabled_starts", starts_total, exp_starts);
    check("disabled_busy", busy, 0);
    check("disabled_fc", frame_count, m_fc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
